spi_slave_rx: RTL

- SPI mode-0 receiver (slave end) for the board's host SPI pins SCK/MOSI/CSb. The OLED path is the SPI master end; this block receives bytes from the external host.
- Oversamples the asynchronous SPI pins in the PLL system clock domain and deserialises bytes.
- Buffers received bytes in a small FIFO and presents them on a valid/ready stream for a downstream command decoder.

---
 rtl/spi_pkg.sv | 25 ++
 rtl/sync_fifo.sv | 57 +++++
 rtl/spi_slave_rx.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and constants for the SPI slave receive path
package spi_pkg;

  localparam int SPI_BYTE_W  = 8;
  localparam int SYNC_STAGES = 2;

  typedef struct packed {
    logic                  sof;
    logic [SPI_BYTE_W-1:0] data;
  } rx_entry_t;

  typedef enum logic {
    FR_IDLE,
    FR_ACTIVE
  } frame_state_t;

  function automatic logic [SPI_BYTE_W-1:0] shift_in(
    input logic [SPI_BYTE_W-1:0] sr,
    input logic                  din,
    input logic                  lsb_first
  );
    return lsb_first ? {din, sr[SPI_BYTE_W-1:1]} : {sr[SPI_BYTE_W-2:0], din};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock show-ahead FIFO, power-of-2 depth
module sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is only taken when the head leaves the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/spi_slave_rx.sv
// rtl/spi_slave_rx.sv - SPI mode-0 slave receiver with byte FIFO and valid/ready output
module spi_slave_rx
  import spi_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic                  clk,
  input  logic                  RSTb,
  input  logic                  SCK,
  input  logic                  MOSI,
  input  logic                  CSb,
  output logic [SPI_BYTE_W-1:0] rx_data,
  output logic                  rx_sof,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  frame_end,
  output logic                  frame_err,
  output logic                  overflow,
  input  logic                  ovf_clr,
  output logic                  busy
);

  localparam int CW   = $clog2(DEPTH) + 1;
  localparam int WARM = SYNC_STAGES + 1;

  logic [SYNC_STAGES:0]   sck_sync;
  logic [SYNC_STAGES:0]   csb_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [1:0]             warm_cnt;

  logic sck_s2, sck_s3, csb_s2, csb_s3, mosi_s2;
  logic warm, sck_rise, csb_rise, csb_fall;

  frame_state_t          state, state_nxt;
  logic                  shift_en;
  logic [2:0]            bit_cnt;
  logic [SPI_BYTE_W-1:0] shreg;
  logic [SPI_BYTE_W-1:0] byte_nxt;
  logic                  sof_pending;

  rx_entry_t       wr_entry, head;
  logic            push, pop, drop;
  logic            fifo_full, fifo_empty;
  logic [CW-1:0]   unused_fifo_count;

  always_ff @(posedge clk or negedge RSTb) begin
    if (!RSTb) begin
      sck_sync  <= '0;
      csb_sync  <= '1;
      mosi_sync <= '0;
      warm_cnt  <= '0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-1:0], SCK};
      csb_sync  <= {csb_sync[SYNC_STAGES-1:0], CSb};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      if (warm_cnt != 2'(WARM)) begin
        warm_cnt <= warm_cnt + 1'b1;
      end
    end
  end

  assign sck_s2  = sck_sync[SYNC_STAGES-1];
  assign sck_s3  = sck_sync[SYNC_STAGES];
  assign csb_s2  = csb_sync[SYNC_STAGES-1];
  assign csb_s3  = csb_sync[SYNC_STAGES];
  assign mosi_s2 = mosi_sync[SYNC_STAGES-1];

  // Edges only count once the history flops hold real pin samples; otherwise
  // CSb held low through reset would look like a fresh fall mid-frame.
  assign warm     = (warm_cnt == 2'(WARM));
  assign sck_rise = warm && sck_s2 && !sck_s3;
  assign csb_rise = warm && csb_s2 && !csb_s3;
  assign csb_fall = warm && !csb_s2 && csb_s3;

  assign busy = ~csb_s2;

  always_ff @(posedge clk or negedge RSTb) begin
    if (!RSTb) begin
      state <= FR_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    shift_en  = 1'b0;
    case (state)
      FR_IDLE: begin
        if (csb_fall) begin
          state_nxt = FR_ACTIVE;
        end
      end
      FR_ACTIVE: begin
        if (csb_s2) begin
          state_nxt = FR_IDLE;
        end else if (sck_rise) begin
          shift_en = 1'b1;
        end
      end
      default: state_nxt = FR_IDLE;
    endcase
  end

  assign byte_nxt = shift_in(shreg, mosi_s2, LSB_FIRST);
  assign push     = shift_en && (bit_cnt == 3'd7);

  always_ff @(posedge clk or negedge RSTb) begin
    if (!RSTb) begin
      bit_cnt     <= '0;
      shreg       <= '0;
      sof_pending <= 1'b0;
      frame_end   <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      frame_end <= csb_rise;
      frame_err <= csb_rise && (bit_cnt != 3'd0);
      if (csb_fall || csb_s2) begin
        bit_cnt <= '0;
      end else if (shift_en) begin
        bit_cnt <= bit_cnt + 1'b1;
        shreg   <= byte_nxt;
      end
      if (csb_fall) begin
        sof_pending <= 1'b1;
      end else if (csb_rise || push) begin
        sof_pending <= 1'b0;
      end
    end
  end

  assign wr_entry = '{sof: sof_pending, data: byte_nxt};
  assign pop      = rx_valid && rx_ready;
  assign drop     = push && fifo_full && !pop;

  sync_fifo #(
    .WIDTH ($bits(rx_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (RSTb),
    .push  (push),
    .wdata (wr_entry),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (unused_fifo_count)
  );

  assign rx_valid = ~fifo_empty;
  assign rx_data  = head.data;
  assign rx_sof   = head.sof;

  always_ff @(posedge clk or negedge RSTb) begin
    if (!RSTb) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

endmodule
